// File: rtl/bf16_pkg.sv
// Shared bfloat16 field widths, constants and packing helpers for the
// multiplier scheduler and its arithmetic core.
package bf16_pkg;

   localparam int BF16_W = 16;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 7;
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
   localparam logic [BF16_W-1:0] POS_ZERO = 16'h0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } bf16_t;

   function automatic logic [BF16_W-1:0] bf16_zero(input logic sign);
      return {sign, POS_ZERO[BF16_W-2:0]};
   endfunction

   function automatic logic [BF16_W-1:0] bf16_inf(input logic sign);
      return {sign, EXP_MAX, {MAN_W{1'b0}}};
   endfunction

   // Returns {normalise_carry, truncated 7-bit mantissa} from the 8x8 significand product.
   function automatic logic [MAN_W:0] mant_norm(input logic [2*(MAN_W+1)-1:0] prod);
      logic [MAN_W-1:0] man;
      man = prod[15] ? prod[14:8] : prod[13:7];
      return {prod[15], man};
   endfunction

endpackage

// File: rtl/bf16_mul_core.sv
// Combinational bfloat16 multiplier: truncating, no NaN/inf special cases,
// flush-to-zero on zero exponent and underflow, saturate to inf on overflow.
module bf16_mul_core
   import bf16_pkg::*;
(
   input  logic [BF16_W-1:0] i_a,
   input  logic [BF16_W-1:0] i_b,
   output logic [BF16_W-1:0] o_p
);

   localparam logic signed [9:0] W_BIAS = 10'(BIAS);

   bf16_t                   w_a;
   bf16_t                   w_b;
   logic                    w_sign;
   logic [15:0]             w_mprod;
   logic [MAN_W:0]          w_mnorm;
   logic signed [9:0]       w_exp;

   assign w_a     = i_a;
   assign w_b     = i_b;
   assign w_sign  = w_a.sign ^ w_b.sign;
   assign w_mprod = {8'd0, 1'b1, w_a.man} * {8'd0, 1'b1, w_b.man};
   assign w_mnorm = mant_norm(w_mprod);
   assign w_exp   = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp})
                    - W_BIAS + $signed({9'd0, w_mnorm[MAN_W]});

   // Result select: zero operands first, then exponent range checks.
   always_comb begin
      o_p = POS_ZERO;
      if ((w_a.exp == 8'd0) || (w_b.exp == 8'd0)) begin
         o_p = bf16_zero(w_sign);
      end else if (w_exp >= 10'sd255) begin
         o_p = bf16_inf(w_sign);
      end else if (w_exp <= 10'sd0) begin
         o_p = bf16_zero(w_sign);
      end else begin
         o_p = {w_sign, w_exp[7:0], w_mnorm[MAN_W-1:0]};
      end
   end

endmodule

// File: rtl/bf16_mul_sched.sv
// Round-robin front end sharing one bfloat16 multiplier core among N_REQ
// requesters through an operand stage (S1) and a result stage (S2).
module bf16_mul_sched
   import bf16_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int N_BIT = 16,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*N_BIT-1:0] req_a,
   input  logic [N_REQ*N_BIT-1:0] req_b,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [N_BIT-1:0]       resp_data,
   output logic [ID_W-1:0]        resp_id,
   output logic                   busy
);

   logic              r_s1_v;
   logic [N_BIT-1:0]  r_s1_a;
   logic [N_BIT-1:0]  r_s1_b;
   logic [ID_W-1:0]   r_s1_id;
   logic              r_s2_v;
   logic [N_BIT-1:0]  r_s2_data;
   logic [ID_W-1:0]   r_s2_id;
   logic [ID_W-1:0]   r_rr_ptr;

   logic              w_s2_adv;
   logic              w_s1_adv;
   logic [ID_W:0]     w_pick;
   logic              w_grant_v;
   logic [ID_W-1:0]   w_grant_id;
   logic [ID_W-1:0]   w_ptr_next;
   logic [N_BIT-1:0]  w_core_p;

   // First valid index scanning upward from ptr with wrap; returns {found, index}.
   function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [ID_W-1:0]  ptr);
      logic              found;
      logic [ID_W-1:0]   id;
      logic [ID_W:0]     idx;
      logic              hit;
      found = 1'b0;
      id    = {ID_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, ptr} + (ID_W+1)'(k);
         idx = (idx >= (ID_W+1)'(N_REQ)) ? idx - (ID_W+1)'(N_REQ) : idx;
         hit = !found && valid[idx[ID_W-1:0]];
         id    = hit ? idx[ID_W-1:0] : id;
         found = found | hit;
      end
      return {found, id};
   endfunction

   assign w_s2_adv = !r_s2_v || resp_ready;
   assign w_s1_adv = !r_s1_v || w_s2_adv;
   assign w_pick   = rr_pick(req_valid, r_rr_ptr);

   // Grant gated by rst_n so req_ready drops the moment reset asserts.
   assign w_grant_v  = rst_n && w_s1_adv && w_pick[ID_W];
   assign w_grant_id = w_pick[ID_W-1:0];
   assign w_ptr_next = (w_grant_id == ID_W'(N_REQ-1)) ? {ID_W{1'b0}} : w_grant_id + ID_W'(1);

   // One-hot ready toward the winning requester only.
   always_comb begin
      req_ready = {N_REQ{1'b0}};
      if (w_grant_v) begin
         req_ready[w_grant_id] = 1'b1;
      end else begin
         req_ready = {N_REQ{1'b0}};
      end
   end

   bf16_mul_core u_core (
      .i_a (r_s1_a),
      .i_b (r_s1_b),
      .o_p (w_core_p)
   );

   // Operand stage and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v   <= 1'b0;
         r_s1_a   <= {N_BIT{1'b0}};
         r_s1_b   <= {N_BIT{1'b0}};
         r_s1_id  <= {ID_W{1'b0}};
         r_rr_ptr <= {ID_W{1'b0}};
      end else if (w_s1_adv) begin
         r_s1_v <= w_grant_v;
         if (w_grant_v) begin
            r_s1_a   <= req_a[w_grant_id*N_BIT +: N_BIT];
            r_s1_b   <= req_b[w_grant_id*N_BIT +: N_BIT];
            r_s1_id  <= w_grant_id;
            r_rr_ptr <= w_ptr_next;
         end
      end
   end

   // Result stage: loads from S1 when it advances, drains when consumed and S1 is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v    <= 1'b0;
         r_s2_data <= {N_BIT{1'b0}};
         r_s2_id   <= {ID_W{1'b0}};
      end else if (w_s1_adv && r_s1_v) begin
         r_s2_v    <= 1'b1;
         r_s2_data <= w_core_p;
         r_s2_id   <= r_s1_id;
      end else if (w_s2_adv) begin
         r_s2_v <= 1'b0;
      end
   end

   assign resp_valid = r_s2_v;
   assign resp_data  = r_s2_data;
   assign resp_id    = r_s2_id;
   assign busy       = r_s1_v || r_s2_v;

endmodule

// File: tb/tb_bf16_mul_sched.sv
// Directed self-checking bench for bf16_mul_sched: grant order, latency,
// backpressure, arithmetic corner cases and asynchronous reset.
module tb_bf16_mul_sched;

   localparam int N_REQ = 4;
   localparam int N_BIT = 16;
   localparam int ID_W  = 2;

   logic                   clk;
   logic                   rst_n;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*N_BIT-1:0] req_a;
   logic [N_REQ*N_BIT-1:0] req_b;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [N_BIT-1:0]       resp_data;
   logic [ID_W-1:0]        resp_id;
   logic                   busy;

   int n_err;
   int n_chk;

   logic [15:0] b_vals [4];

   bf16_mul_sched #(.N_REQ(N_REQ), .N_BIT(N_BIT), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single op on requester 1, response checked two edges after acceptance.
   task automatic arith(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] p);
      req_a[1*N_BIT +: N_BIT] = a;
      req_b[1*N_BIT +: N_BIT] = b;
      req_valid = 4'b0010;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      tick();
      chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
      chk({tag, "_data"}, 32'(resp_data), 32'(p));
      chk({tag, "_id"}, 32'(resp_id), 32'h1);
      tick();
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      b_vals[0] = 16'h4000;
      b_vals[1] = 16'h4040;
      b_vals[2] = 16'h4080;
      b_vals[3] = 16'h40A0;
      rst_n = 1'b0;
      req_valid = 4'b0000;
      req_a = '0;
      req_b = '0;
      resp_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_resp_data", 32'(resp_data), 32'h0);
      chk("rst_resp_id", 32'(resp_id), 32'h0);
      rst_n = 1'b1;
      tick();

      // Single op, requester 2: 1.5 * 1.5 = 2.25
      req_a[2*N_BIT +: N_BIT] = 16'h3FC0;
      req_b[2*N_BIT +: N_BIT] = 16'h3FC0;
      req_valid = 4'b0100;
      resp_ready = 1'b1;
      #1;
      chk("single_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("single_s1_valid", 32'(resp_valid), 32'h0);
      chk("single_s1_busy", 32'(busy), 32'h1);
      tick();
      chk("single_valid", 32'(resp_valid), 32'h1);
      chk("single_data", 32'(resp_data), 32'h4010);
      chk("single_id", 32'(resp_id), 32'h2);
      tick();
      chk("single_drain_valid", 32'(resp_valid), 32'h0);
      chk("single_drain_busy", 32'(busy), 32'h0);

      // All requesters valid from reset: 1.0 * b_i returns b_i
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         req_a[i*N_BIT +: N_BIT] = 16'h3F80;
         req_b[i*N_BIT +: N_BIT] = b_vals[i];
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 7; k++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            chk("rr_resp_valid", 32'(resp_valid), 32'h1);
            chk("rr_resp_id", 32'(resp_id), 32'((k - 2) % 4));
            chk("rr_resp_data", 32'(resp_data), 32'(b_vals[(k - 2) % 4]));
         end else begin
            chk("rr_resp_idle", 32'(resp_valid), 32'h0);
         end
         tick();
      end

      // Reset mid-flight with S1 and S2 full and pointer at 3
      chk("mid_busy_before", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mid_first_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("mid_no_stale_resp", 32'(resp_valid), 32'h0);
      tick();
      chk("mid_resp_valid", 32'(resp_valid), 32'h1);
      chk("mid_resp_id", 32'(resp_id), 32'h0);
      chk("mid_resp_data", 32'(resp_data), 32'h4000);
      tick();

      // Backpressure on requester 0
      resp_ready = 1'b0;
      req_a[0*N_BIT +: N_BIT] = 16'h3FC0;
      req_b[0*N_BIT +: N_BIT] = 16'h3FC0;
      req_valid = 4'b0001;
      #1;
      chk("bp_accept1", 32'(req_ready), 32'h1);
      tick();
      req_a[0*N_BIT +: N_BIT] = 16'hC000;
      req_b[0*N_BIT +: N_BIT] = 16'h4040;
      #1;
      chk("bp_accept2", 32'(req_ready), 32'h1);
      tick();
      chk("bp_stall_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_data", 32'(resp_data), 32'h4010);
      tick();
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      chk("bp_hold_data", 32'(resp_data), 32'h4010);
      chk("bp_hold_id", 32'(resp_id), 32'h0);
      req_valid = 4'b0000;
      resp_ready = 1'b1;
      tick();
      chk("bp_resp2_valid", 32'(resp_valid), 32'h1);
      chk("bp_resp2_data", 32'(resp_data), 32'hC0C0);
      tick();
      chk("bp_drained", 32'(resp_valid), 32'h0);

      // Arithmetic corner cases
      arith("ar_zero", 16'h3F80, 16'h0000, 16'h0000);
      arith("ar_inf", 16'h7F00, 16'h7F00, 16'h7F80);
      arith("ar_under", 16'h0080, 16'h0080, 16'h0000);
      arith("ar_negzero", 16'hBF80, 16'h0000, 16'h8000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
